note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Plays a song for the music player. Steps through a note ROM and drives the write
//  port (en/d) of the 8-bit note register that feeds the tone generator. Each note is
//  held for its ROM-given duration in beats. Supports play, pause, stop and loop.
// PARAMETERS
//  NUM_NOTES  16  ROM depth in note entries
//  ADDR_W     4   ROM address width, clog2(NUM_NOTES)
//  DUR_W      8   duration field width, in beats
//  TICK_DIV   4   clk cycles per beat, >=1 (benches use 2)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous reset, active-low (0 = reset)
//  play      in   1       start/resume request, level
//  pause     in   1       freeze playback while 1
//  stop      in   1       abort to IDLE, silence output
//  loop      in   1       1 = restart at entry 0 after the last note
//  rom_addr  out  ADDR_W  note ROM address (= idx); ROM read is combinational
//  rom_note  in   8       note code at rom_addr
//  rom_dur   in   DUR_W   duration at rom_addr; 0 = end-of-song marker
//  reg_en    out  1       note register write enable
//  reg_d     out  8       note register write data
//  busy      out  1       1 in LOAD or HOLD
//  done      out  1       1 in DONE
// BEHAVIOUR
//  Reset (rst=0, any time, asynchronous):
//   - state=IDLE, idx=0, tick/beat counters=0
//   - reg_en=0, reg_d=0, busy=0, done=0
//  States: IDLE, LOAD, HOLD, DONE.
//  Outputs are combinational from state, inputs and rom_note. Counters and state are flopped.
//  Input priority, evaluated every cycle: stop > pause > play.
//  stop=1 in any state:
//   - reg_en=1, reg_d=0 in that cycle
//   - next state IDLE, idx=0
//  IDLE: play=1 -> LOAD with idx=0. Otherwise stay. reg_en=0.
//  LOAD (exactly 1 cycle):
//   - rom_dur!=0: reg_en=1, reg_d=rom_note. Beat counter=rom_dur, tick=0. Next HOLD.
//   - rom_dur==0: end-of-song handling applies (below); no HOLD.
//   - pause is ignored in LOAD.
//  HOLD:
//   - reg_en=0.
//   - pause=0: tick counts 0..TICK_DIV-1. On wrap, beat counter decrements.
//   - pause=1: tick and beat counters hold.
//   - Timing: each note spans exactly rom_dur*TICK_DIV unpaused cycles, from its LOAD
//     cycle inclusive to the next LOAD/DONE/IDLE transition.
//   - At note expiry:
//     - idx<NUM_NOTES-1: idx+1, next LOAD.
//     - idx==NUM_NOTES-1: end-of-song handling applies.
//  End-of-song handling:
//   - loop=1 and idx!=0: idx=0, next LOAD.
//   - Otherwise: next DONE, with reg_en=1, reg_d=0 in the transition cycle.
//   - Marker at idx 0 with loop=1 goes to DONE, which prevents an infinite zero loop.
//  DONE: done=1, reg_en=0. play=1 -> LOAD, idx=0. Otherwise stay.
//  play is level-sensitive only in IDLE/DONE. Deasserting play mid-song does not stop playback.
//  idx wraps only through loop. It never exceeds NUM_NOTES-1.
// TESTING (TICK_DIV=2, NUM_NOTES=4; ROM = {0x11/d1, 0x22/d2, 0x33/d1, 0x44/d0})
//  reset then play=1 one cycle
//   -> next cycle: LOAD, reg_en=1, reg_d=0x11, rom_addr=0, busy=1
//  free run from play
//   -> reg_en pulses: 0x11@c1, 0x22@c3, 0x33@c7, then 0x00@c9 (marker) and done=1@c10
//  pause=1 for 5 cycles during note 0x22
//   -> next write (0x33) is delayed by exactly 5 cycles; reg_d/rom_addr unchanged meanwhile
//  loop=1, free run
//   -> after 0x33 expires, the write is 0x11 again with rom_addr=0; done is never 1
//  stop=1 during HOLD of 0x22
//   -> same cycle reg_en=1, reg_d=0; next cycle IDLE, busy=0, rom_addr=0
//  rst=0 mid-HOLD (between clock edges)
//   -> outputs go to 0 immediately; after release, play restarts from 0x11

Source files
------------

// File: rtl/note_sequencer.sv
// Song sequencer: walks a combinational note ROM and writes each note into the tone
// generator's note register, holding it for its duration in beats (TICK_DIV clocks each).
module note_sequencer #(
  parameter int NUM_NOTES = 16,
  parameter int ADDR_W    = 4,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic              reg_en,
  output logic [7:0]        reg_d,
  output logic              busy,
  output logic              done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_NOTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     tick;
  logic [DUR_W-1:0]  beat;

  logic marker, load_last, hold_last, expire, song_end, wrap, finish;

  // A note of one beat with TICK_DIV=1 lasts only its LOAD cycle, so it can expire there.
  assign marker    = (state == LOAD) && (rom_dur == '0);
  assign load_last = (state == LOAD) && (TICK_DIV == 1) && (rom_dur == DUR_W'(1));
  assign hold_last = (state == HOLD) && !pause && (tick == TICK_LAST) && (beat == DUR_W'(1));
  assign expire    = load_last || hold_last;
  assign song_end  = marker || (expire && (idx == IDX_LAST));
  assign wrap      = song_end && loop && (idx != '0);
  assign finish    = song_end && !wrap;

  assign rom_addr = idx;
  assign busy     = rst && ((state == LOAD) || (state == HOLD));
  assign done     = rst && (state == DONE);

  always_comb begin
    reg_en = 1'b0;
    reg_d  = 8'h00;
    if (!rst) begin
      reg_en = 1'b0;
    end else if (stop) begin
      reg_en = 1'b1;
    end else if ((state == LOAD) && !marker) begin
      reg_en = 1'b1;
      reg_d  = rom_note;
    end else if (finish) begin
      reg_en = 1'b1;
    end else if (state == HOLD) begin
      reg_d = rom_note;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      tick  <= '0;
      beat  <= '0;
    end else if (stop) begin
      state <= IDLE;
      idx   <= '0;
      tick  <= '0;
      beat  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (play && !pause) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD, HOLD: begin
          if (marker || expire) begin
            if (!song_end) begin
              idx   <= idx + ADDR_W'(1);
              state <= LOAD;
            end else if (wrap) begin
              idx   <= '0;
              state <= LOAD;
            end else begin
              state <= DONE;
            end
          end else if (state == LOAD) begin
            // The LOAD cycle is the first tick of the first beat.
            if (TICK_DIV == 1) begin
              tick <= '0;
              beat <= rom_dur - DUR_W'(1);
            end else begin
              tick <= TW'(1);
              beat <= rom_dur;
            end
            state <= HOLD;
          end else if (!pause) begin
            if (tick == TICK_LAST) begin
              tick <= '0;
              beat <= beat - DUR_W'(1);
            end else begin
              tick <= tick + TW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected register writes are queued with their
// cycle, address and data; a negedge monitor pops one for every reg_en pulse.
module tb_note_sequencer;

  localparam int NUM_NOTES = 4;
  localparam int ADDR_W    = 2;
  localparam int DUR_W     = 8;
  localparam int TICK_DIV  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              play = 1'b0, pause = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              reg_en;
  logic [7:0]        reg_d;
  logic              busy, done;

  typedef struct {
    logic [7:0]        d;
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } write_t;

  write_t expq[$];
  write_t got;
  int cyc = 0;
  int base = 0;
  int checks = 0;
  int fails = 0;

  note_sequencer #(
    .NUM_NOTES(NUM_NOTES), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_note(rom_note), .rom_dur(rom_dur),
    .reg_en(reg_en), .reg_d(reg_d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Song ROM: 0x11 for 1 beat, 0x22 for 2, 0x33 for 1, then the end marker.
  always_comb begin
    rom_note = 8'h00;
    rom_dur  = '0;
    case (rom_addr)
      2'd0: begin rom_note = 8'h11; rom_dur = 8'd1; end
      2'd1: begin rom_note = 8'h22; rom_dur = 8'd2; end
      2'd2: begin rom_note = 8'h33; rom_dur = 8'd1; end
      default: begin rom_note = 8'h44; rom_dur = 8'd0; end
    endcase
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (reg_en === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected write: got d=0x%0h addr=%0d at cycle %0d, expected none",
                 reg_d, rom_addr, cyc - base);
      end else begin
        got = expq.pop_front();
        check_output("write data", int'(reg_d), int'(got.d));
        check_output("write addr", int'(rom_addr), int'(got.addr));
        check_output("write cycle", cyc, got.cyc);
      end
    end
  end

  task automatic apply_stimulus(input logic p, input logic ps, input logic s, input logic l);
    play  = p;
    pause = ps;
    stop  = s;
    loop  = l;
  endtask

  task automatic expect_write(input logic [7:0] d, input int addr, input int n);
    write_t w;
    w.d    = d;
    w.addr = addr[ADDR_W-1:0];
    w.cyc  = base + n;
    expq.push_back(w);
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic drive_at(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_cycle(input int n);
    do @(negedge clk); while (cyc < base + n);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (expq.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_output("pending writes", expq.size(), 0);
    expq.delete();
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, including stop being masked while in reset.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #12;
    check_output("reset reg_en", int'(reg_en), 0);
    check_output("reset reg_d", int'(reg_d), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    check_output("reset rom_addr", int'(rom_addr), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] free run");
    start_cycle();
    expect_write(8'h11, 0, 1);
    expect_write(8'h22, 1, 3);
    expect_write(8'h33, 2, 7);
    expect_write(8'h00, 3, 9);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    goto_cycle(1);
    check_output("first load busy", int'(busy), 1);
    check_output("first load reg_d", int'(reg_d), 8'h11);
    goto_cycle(9);
    check_output("marker cycle done", int'(done), 0);
    goto_cycle(10);
    check_output("song end done", int'(done), 1);
    check_output("song end busy", int'(busy), 0);
    check_output("song end reg_en", int'(reg_en), 0);
    drain(5);

    $display("[TB] pause during 0x22");
    do_reset();
    start_cycle();
    expect_write(8'h11, 0, 1);
    expect_write(8'h22, 1, 3);
    expect_write(8'h33, 2, 12);
    expect_write(8'h00, 3, 14);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    drive_at(4);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    goto_cycle(6);
    check_output("paused reg_d", int'(reg_d), 8'h22);
    check_output("paused rom_addr", int'(rom_addr), 1);
    check_output("paused busy", int'(busy), 1);
    drive_at(9);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    goto_cycle(11);
    check_output("resumed reg_d", int'(reg_d), 8'h22);
    goto_cycle(15);
    check_output("paused song done", int'(done), 1);
    drain(5);

    $display("[TB] loop then stop");
    do_reset();
    start_cycle();
    expect_write(8'h11, 0, 1);
    expect_write(8'h22, 1, 3);
    expect_write(8'h33, 2, 7);
    expect_write(8'h11, 0, 10);
    expect_write(8'h22, 1, 12);
    expect_write(8'h00, 1, 13);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    drive_at(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    goto_cycle(9);
    check_output("loop marker done", int'(done), 0);
    check_output("loop marker rom_addr", int'(rom_addr), 3);
    goto_cycle(10);
    check_output("loop restart rom_addr", int'(rom_addr), 0);
    check_output("loop restart done", int'(done), 0);
    drive_at(13);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    drive_at(14);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    goto_cycle(14);
    check_output("after stop busy", int'(busy), 0);
    check_output("after stop rom_addr", int'(rom_addr), 0);
    check_output("after stop done", int'(done), 0);
    goto_cycle(18);
    check_output("idle after stop busy", int'(busy), 0);
    drain(2);

    $display("[TB] async reset mid-hold");
    do_reset();
    start_cycle();
    expect_write(8'h11, 0, 1);
    expect_write(8'h22, 1, 3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    goto_cycle(4);
    rst = 1'b0;
    #1;
    check_output("async reset busy", int'(busy), 0);
    check_output("async reset reg_en", int'(reg_en), 0);
    check_output("async reset reg_d", int'(reg_d), 0);
    check_output("async reset rom_addr", int'(rom_addr), 0);
    drain(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    start_cycle();
    expect_write(8'h11, 0, 1);
    expect_write(8'h22, 1, 3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    goto_cycle(4);
    check_output("restart hold reg_d", int'(reg_d), 8'h22);
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
